// File: rtl/sequence_checker_if.sv
// rtl/sequence_checker_if.sv - symbol stream and lock/status bundle for sequence_checker
interface sequence_checker_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 valid;
    logic [3:0]           data;
    logic                 locked;
    logic                 err_pulse;
    logic                 frame_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output valid, data,
        input  locked, err_pulse, frame_pulse, err_count
    );

    modport slave (
        input  valid, data,
        output locked, err_pulse, frame_pulse, err_count
    );
endinterface

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - aligns to the A,B,E,7,F,2,0,D symbol stream, flywheels and counts misses
module sequence_checker #(
    parameter int LOCK_THRESH = 3,
    parameter int LOSS_THRESH = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    sequence_checker_if.slave  bus
);
    typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

    localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);
    localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] run;
    logic [3:0] miss;
    logic [3:0] expected;
    logic       hit;

    function automatic logic [3:0] seq_at(input logic [2:0] i);
        case (i)
            3'd0:    seq_at = 4'hA;
            3'd1:    seq_at = 4'hB;
            3'd2:    seq_at = 4'hE;
            3'd3:    seq_at = 4'h7;
            3'd4:    seq_at = 4'hF;
            3'd5:    seq_at = 4'h2;
            3'd6:    seq_at = 4'h0;
            default: seq_at = 4'hD;
        endcase
    endfunction

    assign expected = seq_at(idx);
    // Case equality so an unknown symbol counts as a miss rather than propagating X.
    assign hit      = (bus.data === expected);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= HUNT;
            idx             <= 3'd0;
            run             <= 4'd0;
            miss            <= 4'd0;
            bus.locked      <= 1'b0;
            bus.err_pulse   <= 1'b0;
            bus.frame_pulse <= 1'b0;
            bus.err_count   <= '0;
        end else begin
            bus.err_pulse   <= 1'b0;
            bus.frame_pulse <= 1'b0;
            if (bus.valid) begin
                case (state)
                    HUNT: begin
                        if (bus.data === 4'hA) begin
                            idx <= 3'd1;
                            run <= 4'd1;
                            if (LOCK_T == 4'd1) begin
                                state      <= LOCKED;
                                bus.locked <= 1'b1;
                            end else begin
                                state <= ALIGN;
                            end
                        end
                    end
                    ALIGN: begin
                        if (hit) begin
                            idx <= idx + 3'd1;
                            run <= run + 4'd1;
                            if (run + 4'd1 == LOCK_T) begin
                                state      <= LOCKED;
                                bus.locked <= 1'b1;
                            end
                        end else if (bus.data === 4'hA) begin
                            idx <= 3'd1;
                            run <= 4'd1;
                        end else begin
                            state <= HUNT;
                            idx   <= 3'd0;
                            run   <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: position advances regardless of the received symbol.
                        idx <= idx + 3'd1;
                        if (hit) begin
                            miss <= 4'd0;
                            if (expected == 4'hD)
                                bus.frame_pulse <= 1'b1;
                        end else begin
                            bus.err_pulse <= 1'b1;
                            if (bus.err_count != '1)
                                bus.err_count <= bus.err_count + 1'b1;
                            if (miss + 4'd1 == LOSS_T) begin
                                state      <= HUNT;
                                bus.locked <= 1'b0;
                                miss       <= 4'd0;
                                run        <= 4'd0;
                            end else begin
                                miss <= miss + 4'd1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - randomized bench for sequence_checker against a behavioural model
module tb_sequence_checker;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid_d;
    logic [3:0] data_d;

    always #5 clk = ~clk;

    sequence_checker_if #(.ERR_CNT_W(8)) if0 ();
    sequence_checker_if #(.ERR_CNT_W(2)) if1 ();
    sequence_checker_if #(.ERR_CNT_W(4)) if2 ();

    assign if0.valid = valid_d;
    assign if0.data  = data_d;
    assign if1.valid = valid_d;
    assign if1.data  = data_d;
    assign if2.valid = valid_d;
    assign if2.data  = data_d;

    sequence_checker #(.LOCK_THRESH(3), .LOSS_THRESH(2), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0));
    sequence_checker #(.LOCK_THRESH(3), .LOSS_THRESH(2), .ERR_CNT_W(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1));
    sequence_checker #(.LOCK_THRESH(1), .LOSS_THRESH(1), .ERR_CNT_W(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(if2));

    logic       obs_lock  [3];
    logic       obs_err   [3];
    logic       obs_frame [3];
    logic [7:0] obs_cnt   [3];

    assign obs_lock[0]  = if0.locked;
    assign obs_lock[1]  = if1.locked;
    assign obs_lock[2]  = if2.locked;
    assign obs_err[0]   = if0.err_pulse;
    assign obs_err[1]   = if1.err_pulse;
    assign obs_err[2]   = if2.err_pulse;
    assign obs_frame[0] = if0.frame_pulse;
    assign obs_frame[1] = if1.frame_pulse;
    assign obs_frame[2] = if2.frame_pulse;
    assign obs_cnt[0]   = if0.err_count;
    assign obs_cnt[1]   = {6'd0, if1.err_count};
    assign obs_cnt[2]   = {4'd0, if2.err_count};

    logic [3:0] seq_tab [8] = '{4'hA, 4'hB, 4'hE, 4'h7, 4'hF, 4'h2, 4'h0, 4'hD};
    int lock_th [3] = '{3, 3, 1};
    int loss_th [3] = '{2, 2, 1};
    int cnt_max [3] = '{255, 3, 15};

    bit m_lock  [3];
    bit m_err   [3];
    bit m_frame [3];
    int m_pos   [3];
    int m_run   [3];
    int m_miss  [3];
    int m_cnt   [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_frames;

    task automatic model_reset(input int k);
        m_lock[k] = 0; m_err[k] = 0; m_frame[k] = 0;
        m_pos[k] = 0; m_run[k] = 0; m_miss[k] = 0; m_cnt[k] = 0;
    endtask

    // Hunting is "not locked with an empty run"; aligning is "not locked, run>0".
    task automatic model_step(input int k, input logic v, input logic [3:0] d);
        logic [3:0] exp_sym;
        m_err[k] = 0;
        m_frame[k] = 0;
        if (!v) return;
        if (!m_lock[k]) begin
            if (m_run[k] == 0) begin
                if (d === 4'hA) begin
                    m_run[k] = 1;
                    m_pos[k] = 1;
                    if (lock_th[k] == 1) m_lock[k] = 1;
                end
            end else if (d === seq_tab[m_pos[k]]) begin
                m_run[k] = m_run[k] + 1;
                m_pos[k] = (m_pos[k] + 1) % 8;
                if (m_run[k] == lock_th[k]) m_lock[k] = 1;
            end else if (d === 4'hA) begin
                m_run[k] = 1;
                m_pos[k] = 1;
            end else begin
                m_run[k] = 0;
            end
        end else begin
            exp_sym  = seq_tab[m_pos[k]];
            m_pos[k] = (m_pos[k] + 1) % 8;
            if (d === exp_sym) begin
                m_miss[k] = 0;
                if (exp_sym == 4'hD) m_frame[k] = 1;
            end else begin
                m_err[k] = 1;
                if (m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
                m_miss[k] = m_miss[k] + 1;
                if (m_miss[k] == loss_th[k]) begin
                    m_lock[k] = 0;
                    m_miss[k] = 0;
                    m_run[k]  = 0;
                end
            end
        end
    endtask

    // Drive one cycle from a negedge, advance the model on the posedge, score at the next negedge.
    task automatic send(input logic v, input logic [3:0] d);
        valid_d = v;
        data_d  = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) model_reset(k);
            else model_step(k, v, d);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp += 4;
            if (obs_lock[k] !== m_lock[k]) begin
                n_fail++;
                $display("FAIL locked inst%0d t=%0t got %0b exp %0b", k, $time, obs_lock[k], m_lock[k]);
            end
            if (obs_err[k] !== m_err[k]) begin
                n_fail++;
                $display("FAIL err_pulse inst%0d t=%0t got %0b exp %0b", k, $time, obs_err[k], m_err[k]);
            end
            if (obs_frame[k] !== m_frame[k]) begin
                n_fail++;
                $display("FAIL frame_pulse inst%0d t=%0t got %0b exp %0b", k, $time, obs_frame[k], m_frame[k]);
            end
            if (obs_cnt[k] !== 8'(m_cnt[k])) begin
                n_fail++;
                $display("FAIL err_count inst%0d t=%0t got %0d exp %0d", k, $time, obs_cnt[k], m_cnt[k]);
            end
        end
        if (obs_frame[0] === 1'b1) n_frames++;
    endtask

    task automatic send_seq(input logic [3:0] syms [], input int gap);
        foreach (syms[i]) begin
            send(1'b1, syms[i]);
            repeat (gap) send(1'b0, 4'($urandom));
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        send(1'b1, 4'hA);
        send(1'b1, 4'hA);
        n_cmp++;
        if (if0.locked !== 1'b0 || if0.err_count !== 8'd0 || if0.err_pulse !== 1'b0 || if0.frame_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got lock=%0b cnt=%0d ep=%0b fp=%0b exp all 0",
                     if0.locked, if0.err_count, if0.err_pulse, if0.frame_pulse);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_lock_and_wrap;
        n_frames = 0;
        send_seq('{4'hA, 4'hB, 4'hE}, 0);
        n_cmp++;
        if (if0.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_after_E got %0b exp 1", if0.locked);
        end
        send_seq('{4'h7, 4'hF, 4'h2, 4'h0, 4'hD, 4'hA, 4'hB, 4'hE, 4'h7, 4'hF, 4'h2, 4'h0, 4'hD}, 0);
        n_cmp++;
        if (n_frames !== 2 || if0.err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_frames got frames=%0d cnt=%0d exp frames=2 cnt=0", n_frames, if0.err_count);
        end
    endtask

    task automatic test_single_error;
        send_seq('{4'hA, 4'hB, 4'hE, 4'h7, 4'h5}, 0);
        n_cmp++;
        if (if0.err_pulse !== 1'b1 || if0.err_count !== 8'd1 || if0.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL single_error got ep=%0b cnt=%0d lock=%0b exp ep=1 cnt=1 lock=1",
                     if0.err_pulse, if0.err_count, if0.locked);
        end
        send_seq('{4'h2, 4'h0}, 0);
        n_cmp++;
        if (if0.err_pulse !== 1'b0 || if0.err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL after_error got ep=%0b cnt=%0d exp ep=0 cnt=1", if0.err_pulse, if0.err_count);
        end
    endtask

    task automatic test_loss_relock;
        send_seq('{4'h3, 4'h3}, 0);
        n_cmp++;
        if (if0.locked !== 1'b0 || if0.err_count !== 8'd3) begin
            n_fail++;
            $display("FAIL loss got lock=%0b cnt=%0d exp lock=0 cnt=3", if0.locked, if0.err_count);
        end
        send_seq('{4'hA, 4'hB, 4'hE}, 0);
        n_cmp++;
        if (if0.locked !== 1'b1 || if0.err_count !== 8'd3) begin
            n_fail++;
            $display("FAIL relock got lock=%0b cnt=%0d exp lock=1 cnt=3", if0.locked, if0.err_count);
        end
    endtask

    task automatic test_hunt_gaps;
        reset_n = 1'b0;
        send(1'b0, 4'h0);
        reset_n = 1'b1;
        send_seq('{4'hB, 4'hE, 4'hA, 4'hB, 4'h7, 4'hA, 4'hB, 4'hE}, 3);
        n_cmp++;
        if (if0.locked !== 1'b1 || if0.err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL hunt_gaps got lock=%0b cnt=%0d exp lock=1 cnt=0", if0.locked, if0.err_count);
        end
    endtask

    task automatic test_saturation_and_reset;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, seq_tab[m_pos[0]] ^ 4'h5);
            send(1'b1, seq_tab[m_pos[0]]);
            send(1'b1, seq_tab[m_pos[0]]);
        end
        n_cmp++;
        if (if1.err_count !== 2'd3 || if0.err_count !== 8'd5) begin
            n_fail++;
            $display("FAIL saturation got w2=%0d w8=%0d exp w2=3 w8=5", if1.err_count, if0.err_count);
        end
        reset_n = 1'b0;
        send(1'b1, seq_tab[m_pos[0]]);
        reset_n = 1'b1;
        n_cmp++;
        if (if0.locked !== 1'b0 || if0.err_count !== 8'd0 || if1.err_count !== 2'd0) begin
            n_fail++;
            $display("FAIL midlock_reset got lock=%0b cnt=%0d exp lock=0 cnt=0", if0.locked, if0.err_count);
        end
    endtask

    task automatic test_random;
        logic [3:0] d;
        logic       v;
        int         r;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 80)      d = seq_tab[m_pos[0]];
            else if (r < 88) d = 4'hA;
            else if (r < 98) d = 4'($urandom);
            else             d = 4'bxxxx;
            reset_n = ($urandom_range(0, 499) != 0);
            send(v, d);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        valid_d = 1'b0;
        data_d  = 4'h0;
        for (int k = 0; k < 3; k++) model_reset(k);
        @(negedge clk);
        test_reset;
        test_lock_and_wrap;
        test_single_error;
        test_loss_relock;
        test_hunt_gaps;
        test_saturation_and_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
